booth_job_sequencer: RTL and testbench

BOOTH_JOB_SEQUENCER -- requirements
Module: booth_job_sequencer

---
 rtl/booth_job_sequencer.sv | 125 ++++++++++++
 tb/tb_booth_job_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_job_sequencer.sv
// Job sequencer wrapping a Booth multiplier controller: accepts operand pairs,
// runs the controller under a watchdog, and holds each product in a one-deep output slot.
module booth_job_sequencer #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [WIDTH-1:0]     in_q,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_m,
    output logic [WIDTH-1:0]     mul_q,
    input  logic                 mul_done,
    input  logic [2*WIDTH-1:0]   mul_prod,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic                 err,
    output logic                 busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and the offered data holds until taken.

    localparam int WD_W = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [WIDTH-1:0]     mul_m_q, mul_m_d;
    logic [WIDTH-1:0]     mul_q_q, mul_q_d;
    logic                 out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0]   out_prod_q, out_prod_d;

    logic accept;
    logic capture;
    logic timeout;

    always_comb begin
        in_ready = (state_q == IDLE) && !rst;
        accept   = in_valid && in_ready;
        // A finished product is only taken when the output slot can hold it.
        capture  = (state_q == RUN) && mul_done && (!out_valid_q || out_ready);
        timeout  = (state_q == RUN) && !mul_done && (wd_q == WD_LIMIT);
    end

    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        mul_m_d     = mul_m_q;
        mul_q_d     = mul_q_q;
        out_valid_d = out_valid_q;
        out_prod_d  = out_prod_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    wd_d    = '0;
                    mul_m_d = in_m;
                    mul_q_d = in_q;
                end
            end
            RUN: begin
                if (capture || timeout) begin
                    state_d = DRAIN;
                end else if (!mul_done) begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Capture and consume on the same edge replace the slot without a bubble.
        if (capture) begin
            out_valid_d = 1'b1;
            out_prod_d  = mul_prod;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wd_q        <= '0;
            mul_m_q     <= '0;
            mul_q_q     <= '0;
            out_valid_q <= 1'b0;
            out_prod_q  <= '0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            mul_m_q     <= mul_m_d;
            mul_q_q     <= mul_q_d;
            out_valid_q <= out_valid_d;
            out_prod_q  <= out_prod_d;
        end
    end

    always_comb begin
        mul_start = (state_q == RUN);
        busy      = (state_q != IDLE);
        mul_m     = mul_m_q;
        mul_q     = mul_q_q;
        out_valid = out_valid_q;
        out_prod  = out_prod_q;
        err       = timeout && !rst;
    end

endmodule

// File: tb/tb_booth_job_sequencer.sv
// Bench for booth_job_sequencer: a latency-programmable Booth controller stand-in,
// a job-level reference model with a result queue, and directed scenario checks.
module tb_booth_job_sequencer;

    localparam int W  = 8;
    localparam int TO = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_m;
    logic [W-1:0]     in_q;
    logic             mul_start;
    logic [W-1:0]     mul_m;
    logic [W-1:0]     mul_q;
    logic             mul_done;
    logic [2*W-1:0]   mul_prod;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_prod;
    logic             err;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    booth_job_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_m      (in_m),
        .in_q      (in_q),
        .mul_start (mul_start),
        .mul_m     (mul_m),
        .mul_q     (mul_q),
        .mul_done  (mul_done),
        .mul_prod  (mul_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .err       (err),
        .busy      (busy)
    );

    function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
    endfunction

    // Controller stand-in: Done rises after lat cycles of start, holds while start is high.
    int         lat     = 2;
    logic       done_en = 1'b1;
    logic [3:0] ctl_cnt = '0;

    always @(posedge clk) begin
        if (!mul_start) ctl_cnt <= '0;
        else if (ctl_cnt != 4'hF) ctl_cnt <= ctl_cnt + 4'd1;
    end

    assign mul_done = done_en && mul_start && (int'(ctl_cnt) >= lat);
    assign mul_prod = mul_done ? prod(mul_m, mul_q) : {W{2'b10}};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Job-level reference: operands of the last accepted job, cycles since acceptance,
    // and the queue of products still owed to the consumer.
    logic [W-1:0]   ref_m  = '0;
    logic [W-1:0]   ref_q  = '0;
    int             since  = 0;
    bit             active = 0;
    int             n_results = 0;
    logic [2*W-1:0] exp_q[$];

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                ref_m  = '0;
                ref_q  = '0;
                since  = 0;
                active = 0;
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                ref_m  = in_m;
                ref_q  = in_q;
                since  = 1;
                active = 1;
                if (done_en) exp_q.push_back(prod(in_m, in_q));
            end else if (active) begin
                since++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("mul_m_model", mul_m, ref_m);
            check("mul_q_model", mul_q, ref_q);
            check("err_model", err, (!done_en && active && since == TO));
            if (out_valid && out_ready) begin
                n_results++;
                if (exp_q.size() == 0) fail("unexpected_result");
                else check("result_order", out_prod, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] m, input logic [W-1:0] q, input bit hold, output int acc_cyc);
        bit ok;
        ok = 0;
        acc_cyc = -1;
        in_valid = 1'b1;
        in_m = m;
        in_q = q;
        for (int n = 0; n < 100; n++) begin
            if (in_ready) begin
                ok = 1;
                step();
                acc_cyc = cyc;
                break;
            end
            step();
        end
        if (!ok) fail("accept_wait");
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int n = 0; n < 64; n++) begin
            if (mul_done) begin
                ok = 1;
                break;
            end
            step();
        end
        if (!ok) fail("done_wait");
    endtask

    task automatic wait_out_valid();
        bit ok;
        ok = 0;
        for (int n = 0; n < 64; n++) begin
            if (out_valid) begin
                ok = 1;
                break;
            end
            step();
        end
        if (!ok) fail("out_valid_wait");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    logic [W-1:0] tm[4] = '{8'h7F, 8'h80, 8'h80, 8'hFF};
    logic [W-1:0] tq[4] = '{8'h7F, 8'h80, 8'h7F, 8'h01};
    int acc[4];
    int dummy;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_m = '0; in_q = '0; out_ready = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_mul_start", mul_start, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_prod", out_prod, 16'h0000);
        check("rst_mul_m", mul_m, 8'h00);
        check("rst_mul_q", mul_q, 8'h00);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", in_ready, 1'b1);

        // Basic multiply: 3 x -2
        lat = 2;
        send(8'h03, 8'hFE, 0, dummy);
        check("basic_mul_start", mul_start, 1'b1);
        check("basic_mul_m", mul_m, 8'h03);
        check("basic_mul_q", mul_q, 8'hFE);
        check("basic_in_ready_run", in_ready, 1'b0);
        wait_done();
        check("basic_no_early_valid", out_valid, 1'b0);
        step();
        check("basic_out_valid", out_valid, 1'b1);
        check("basic_out_prod", out_prod, 16'hFFFA);
        check("basic_drain_start", mul_start, 1'b0);
        check("basic_drain_busy", busy, 1'b1);
        step();
        check("basic_idle_busy", busy, 1'b0);
        check("basic_idle_ready", in_ready, 1'b1);
        check("basic_consumed", out_valid, 1'b0);

        // Backpressure: first result parked, second job (5 x 7) stalls on Done
        out_ready = 1'b0;
        send(8'h02, 8'h09, 0, dummy);
        wait_out_valid();
        check("bp_first_prod", out_prod, 16'h0012);
        send(8'h05, 8'h07, 0, dummy);
        wait_done();
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_start", mul_start, 1'b1);
            check("bp_hold_done", mul_done, 1'b1);
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_prod", out_prod, 16'h0012);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp_swap_valid", out_valid, 1'b1);
        check("bp_swap_prod", out_prod, 16'h0023);
        check("bp_swap_start", mul_start, 1'b0);
        step();
        check("bp_drained", out_valid, 1'b0);

        // Timeout: Done never rises
        done_en = 1'b0;
        send(8'h11, 8'h22, 0, dummy);
        for (int k = 1; k <= TO; k++) begin
            check("to_err", err, (k == TO));
            check("to_out_valid", out_valid, 1'b0);
            if (k < TO) step();
        end
        step();
        check("to_drain_err", err, 1'b0);
        check("to_drain_busy", busy, 1'b1);
        check("to_drain_start", mul_start, 1'b0);
        step();
        check("to_idle_busy", busy, 1'b0);
        check("to_idle_valid", out_valid, 1'b0);
        check("to_out_prod_kept", out_prod, 16'h0023);
        done_en = 1'b1;

        // Reset three cycles into a long job
        lat = 6;
        send(8'h07, 8'h07, 0, dummy);
        repeat (3) step();
        check("mr_start_before", mul_start, 1'b1);
        rst = 1'b1;
        check("mr_err_rst", err, 1'b0);
        step();
        check("mr_start", mul_start, 1'b0);
        check("mr_out_valid", out_valid, 1'b0);
        check("mr_err", err, 1'b0);
        check("mr_busy", busy, 1'b0);
        check("mr_in_ready_rst", in_ready, 1'b0);
        check("mr_mul_m", mul_m, 8'h00);
        check("mr_out_prod", out_prod, 16'h0000);
        rst = 1'b0;
        step();
        check("mr_in_ready", in_ready, 1'b1);
        check("mr_start_after", mul_start, 1'b0);
        check("mr_valid_after", out_valid, 1'b0);
        check("mr_err_after", err, 1'b0);

        // Back-to-back with in_valid held high
        lat = 1;
        for (int i = 0; i < 4; i++) send(tm[i], tq[i], 1, acc[i]);
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) check("b2b_spacing", acc[i] - acc[i-1], 4);
        repeat (10) step();
        check("b2b_queue_empty", exp_q.size(), 0);
        check("total_results", n_results, 7);
        check("end_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
